add_lane_pipe: RTL and testbench

Parametrised, multi-lane, back-pressurable pipelined adder for the add bench. It generalises the single fixed-width adder behind the add_in/add_out agents to LANES independent a+b lanes of DATA_W bits each. The lanes share one valid/ready handshake and a pipeline of PIPE_DEPTH elastic stages that collapse bubbles. It sits between the add_in-side driver interface and the add_out-side monitor interface.

---
 rtl/add_lane_pipe.sv | 131 +++++++++++++
 tb/tb_add_lane_pipe.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/add_lane_pipe.sv
// Multi-lane elastic pipelined adder: LANES independent a+b lanes sharing one valid/ready pipeline.
// Optional macro ADD_LANE_PIPE_SAT_EN clamps overflowing lanes and counts saturation events.
module add_lane_pipe #(
    parameter int DATA_W     = 8,
    parameter int LANES      = 2,
    parameter int PIPE_DEPTH = 2,
    parameter int TAG_W      = 4
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [LANES*DATA_W-1:0]          in_a,
    input  logic [LANES*DATA_W-1:0]          in_b,
    input  logic [TAG_W-1:0]                 in_tag,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [LANES*(DATA_W+1)-1:0]      out_sum,
    output logic [TAG_W-1:0]                 out_tag,
    output logic [$clog2(PIPE_DEPTH+1)-1:0]  occupancy,
    output logic [15:0]                      sat_count
);

    localparam int SUM_W = LANES * (DATA_W + 1);
    localparam int OCC_W = $clog2(PIPE_DEPTH + 1);
    localparam int LAST  = PIPE_DEPTH - 1;

    logic [PIPE_DEPTH-1:0] r_v;
    logic [SUM_W-1:0]      r_sum [PIPE_DEPTH];
    logic [TAG_W-1:0]      r_tag [PIPE_DEPTH];

    logic [PIPE_DEPTH-1:0] w_en;
    logic [SUM_W-1:0]      w_sum0;
    logic [DATA_W:0]       w_lane;
    logic [OCC_W-1:0]      w_occ;
    logic                  w_accept;
    logic                  w_tail_full;
`ifdef ADD_LANE_PIPE_SAT_EN
    logic [15:0]           w_sat_num;
    logic [16:0]           w_sat_next;
    logic [15:0]           r_sat_count;
`endif

    // Handshake: a transfer happens on a rising edge where valid && ready; ready never waits on valid.
    // Stage k may advance unless it and every stage downstream of it are full while out_ready is low.
    always_comb begin
        w_en        = '0;
        w_tail_full = 1'b1;
        for (int k = LAST; k >= 0; k--) begin
            w_tail_full = w_tail_full & r_v[k];
            w_en[k]     = ~w_tail_full | out_ready;
        end
    end

    assign w_accept = in_valid & w_en[0] & ~reset;

    always_comb begin
        w_sum0 = '0;
        w_lane = '0;
`ifdef ADD_LANE_PIPE_SAT_EN
        w_sat_num = '0;
`endif
        for (int i = 0; i < LANES; i++) begin
            w_lane = {1'b0, in_a[i*DATA_W +: DATA_W]} + {1'b0, in_b[i*DATA_W +: DATA_W]};
`ifdef ADD_LANE_PIPE_SAT_EN
            if (w_lane[DATA_W]) begin
                w_lane    = {1'b0, {DATA_W{1'b1}}};
                w_sat_num = w_sat_num + 16'd1;
            end
`endif
            w_sum0[i*(DATA_W+1) +: DATA_W+1] = w_lane;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_v <= '0;
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                r_sum[k] <= '0;
                r_tag[k] <= '0;
            end
        end else begin
            if (w_en[0]) begin
                r_v[0] <= w_accept;
                if (w_accept) begin
                    r_sum[0] <= w_sum0;
                    r_tag[0] <= in_tag;
                end
            end
            for (int k = 1; k < PIPE_DEPTH; k++) begin
                if (w_en[k]) begin
                    r_v[k]   <= r_v[k-1];
                    r_sum[k] <= r_sum[k-1];
                    r_tag[k] <= r_tag[k-1];
                end
            end
        end
    end

    always_comb begin
        w_occ = '0;
        for (int k = 0; k < PIPE_DEPTH; k++) begin
            w_occ = w_occ + OCC_W'(r_v[k]);
        end
    end

`ifdef ADD_LANE_PIPE_SAT_EN
    assign w_sat_next = {1'b0, r_sat_count} + {1'b0, w_sat_num};

    // Counter sticks at all-ones rather than wrapping.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sat_count <= '0;
        end else if (w_accept) begin
            r_sat_count <= w_sat_next[16] ? 16'hFFFF : w_sat_next[15:0];
        end
    end

    assign sat_count = r_sat_count;
`else
    assign sat_count = '0;
`endif

    // Outputs read as idle for the whole reset cycle, not just after the reset edge.
    assign in_ready  = w_en[0] | reset;
    assign out_valid = r_v[LAST] & ~reset;
    assign out_sum   = reset ? '0 : r_sum[LAST];
    assign out_tag   = reset ? '0 : r_tag[LAST];
    assign occupancy = reset ? '0 : w_occ;

endmodule

// File: tb/tb_add_lane_pipe.sv
// Directed bench for add_lane_pipe (default parameters) with an in-order expected queue.
module tb_add_lane_pipe;

    localparam int DATA_W     = 8;
    localparam int LANES      = 2;
    localparam int PIPE_DEPTH = 2;
    localparam int TAG_W      = 4;
    localparam int SUM_W      = LANES * (DATA_W + 1);
    localparam int OCC_W      = $clog2(PIPE_DEPTH + 1);

    logic                    clock;
    logic                    reset;
    logic                    in_valid;
    logic                    in_ready;
    logic [LANES*DATA_W-1:0] in_a;
    logic [LANES*DATA_W-1:0] in_b;
    logic [TAG_W-1:0]        in_tag;
    logic                    out_valid;
    logic                    out_ready;
    logic [SUM_W-1:0]        out_sum;
    logic [TAG_W-1:0]        out_tag;
    logic [OCC_W-1:0]        occupancy;
    logic [15:0]             sat_count;

    add_lane_pipe #(
        .DATA_W(DATA_W), .LANES(LANES), .PIPE_DEPTH(PIPE_DEPTH), .TAG_W(TAG_W)
    ) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_tag(out_tag),
        .occupancy(occupancy), .sat_count(sat_count)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [SUM_W+TAG_W-1:0] exp_q[$];
    logic [SUM_W+TAG_W-1:0] cur_exp;
    logic [SUM_W+TAG_W-1:0] ent;
    int n_vec;
    int n_err;
    int n_pop;
    logic [15:0] exp_sat;

    logic [15:0]      va [9];
    logic [15:0]      vb [9];
    logic [SUM_W-1:0] ve [9];

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic drive(input int idx, input logic [TAG_W-1:0] tag);
        in_valid = 1'b1;
        in_a     = va[idx];
        in_b     = vb[idx];
        in_tag   = tag;
        cur_exp  = {tag, ve[idx]};
    endtask

    // scoreboard: outputs pop in order, accepted inputs push their hand-computed result
    always @(negedge clock) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 32'(out_valid), 32'd0);
                end else begin
                    ent = exp_q.pop_front();
                    check("sb_tag", 32'(out_tag), 32'(ent[SUM_W+TAG_W-1:SUM_W]));
                    check("sb_sum", 32'(out_sum), 32'(ent[SUM_W-1:0]));
                    n_pop++;
                end
            end
            if (in_valid && in_ready) exp_q.push_back(cur_exp);
        end
    end

    initial begin
        n_vec = 0; n_err = 0; n_pop = 0; exp_sat = 16'd0;
        va = '{16'h0102, 16'h8080, 16'h00FF, 16'h7F01, 16'h5533, 16'hFFFF, 16'h1234, 16'hAA00, 16'h10FF};
        vb = '{16'h0304, 16'h8080, 16'h0000, 16'h01FF, 16'h2211, 16'hFFFF, 16'h4321, 16'h5500, 16'h0501};
`ifdef ADD_LANE_PIPE_SAT_EN
        ve = '{{9'h004, 9'h006}, {9'h0FF, 9'h0FF}, {9'h000, 9'h0FF}, {9'h080, 9'h0FF}, {9'h077, 9'h044},
               {9'h0FF, 9'h0FF}, {9'h055, 9'h055}, {9'h0FF, 9'h000}, {9'h015, 9'h0FF}};
`else
        ve = '{{9'h004, 9'h006}, {9'h100, 9'h100}, {9'h000, 9'h0FF}, {9'h080, 9'h100}, {9'h077, 9'h044},
               {9'h1FE, 9'h1FE}, {9'h055, 9'h055}, {9'h0FF, 9'h000}, {9'h015, 9'h100}};
`endif
        reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1; cur_exp = '0;

        // reset then idle
        step(); step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_occupancy", 32'(occupancy), 32'd0);
        check("rst_sat", 32'(sat_count), 32'd0);
        reset = 1'b0;
        step();
        check("idle_out_valid", 32'(out_valid), 32'd0);
        check("idle_out_sum", 32'(out_sum), 32'd0);
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // single transaction, two-cycle latency
        drive(8, 4'h3);
        step();
        in_valid = 1'b0;
        check("single_early", 32'(out_valid), 32'd0);
        check("single_occ1", 32'(occupancy), 32'd1);
        step();
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_sum", 32'(out_sum), 32'(ve[8]));
        check("single_tag", 32'(out_tag), 32'd3);
`ifdef ADD_LANE_PIPE_SAT_EN
        exp_sat = 16'd1;
`endif
        check("single_sat", 32'(sat_count), 32'(exp_sat));
        step();
        check("single_done", 32'(out_valid), 32'd0);

        // back-to-back burst of 8
        for (int i = 0; i < 8; i++) begin
            drive(i, TAG_W'(i));
            check("b2b_in_ready", 32'(in_ready), 32'd1);
            step();
            if (i > 0) begin
                check("b2b_valid", 32'(out_valid), 32'd1);
                check("b2b_tag", 32'(out_tag), 32'(i - 1));
            end
        end
        in_valid = 1'b0;
        step();
        check("b2b_last_valid", 32'(out_valid), 32'd1);
        check("b2b_last_tag", 32'(out_tag), 32'd7);
        step();
        check("b2b_empty", 32'(out_valid), 32'd0);
        check("b2b_pops", 32'(n_pop), 32'd9);
`ifdef ADD_LANE_PIPE_SAT_EN
        exp_sat = 16'd6;
`endif
        check("b2b_sat", 32'(sat_count), 32'(exp_sat));

        // back-pressure: two fill, third waits
        out_ready = 1'b0;
        drive(0, 4'h8);
        check("bp_rdy0", 32'(in_ready), 32'd1);
        step();
        drive(4, 4'h9);
        step();
        drive(6, 4'hA);
        check("bp_full_rdy", 32'(in_ready), 32'd0);
        check("bp_full_occ", 32'(occupancy), 32'd2);
        check("bp_full_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_hold_sum", 32'(out_sum), 32'(ve[0]));
            check("bp_hold_tag", 32'(out_tag), 32'h8);
            check("bp_hold_rdy", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_rdy", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check("bp_shift_tag", 32'(out_tag), 32'h9);
        check("bp_shift_occ", 32'(occupancy), 32'd2);
        step();
        check("bp_third_tag", 32'(out_tag), 32'hA);
        check("bp_third_occ", 32'(occupancy), 32'd1);
        step();
        check("bp_drained", 32'(occupancy), 32'd0);

        // bubble collapse behind a stalled result
        out_ready = 1'b0;
        drive(2, 4'h1);
        step();
        in_valid = 1'b0;
        step(); step(); step();
        check("bub_occ1", 32'(occupancy), 32'd1);
        check("bub_rdy", 32'(in_ready), 32'd1);
        drive(7, 4'h2);
        step();
        in_valid = 1'b0;
        check("bub_occ2", 32'(occupancy), 32'd2);
        check("bub_tag", 32'(out_tag), 32'h1);
        check("bub_sum", 32'(out_sum), 32'(ve[2]));
        check("bub_rdy_full", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 10 && occupancy != 0; i++) step();
        check("bub_drained", 32'(occupancy), 32'd0);

        // reset with the pipeline full
        out_ready = 1'b0;
        drive(0, 4'h5);
        step();
        drive(6, 4'h6);
        step();
        in_valid = 1'b0;
        check("mid_occ", 32'(occupancy), 32'd2);
        reset = 1'b1;
        step();
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_occ", 32'(occupancy), 32'd0);
        check("mid_rst_rdy", 32'(in_ready), 32'd1);
        check("mid_rst_sum", 32'(out_sum), 32'd0);
        check("mid_rst_tag", 32'(out_tag), 32'd0);
        check("mid_rst_sat", 32'(sat_count), 32'd0);
        reset = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("post_rst_valid", 32'(out_valid), 32'd0);
            check("post_rst_occ", 32'(occupancy), 32'd0);
        end

`ifdef ADD_LANE_PIPE_SAT_EN
        // 33000 transactions x 2 saturating lanes overruns 0xFFFF
        drive(5, 4'h4);
        for (int i = 0; i < 33000; i++) step();
        in_valid = 1'b0;
        step(); step(); step();
        check("sat_ceiling", 32'(sat_count), 32'hFFFF);
`endif

        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
